forward_dense: RTL
==================

// Module: forward_dense
// PURPOSE
//  Forward-pass dense layer: z = W*x + b, predict_value = act(z), signed fixed point.
//  Produces the z / predict_value vectors consumed by the backward-pass derivative block.
//  Serial single-multiplier MAC engine with valid/ready handshakes on both ends.
// PARAMETERS
//  size            3   neurons per layer = inputs per neuron
//  data_size       16  element width, signed two's complement
//  frac_bits       8   fractional bits (Q(data_size-frac_bits).frac_bits)
//  dense_type_size 4   width of activation select
// PORTS
//  clk              in   1                      clock, rising edge
//  rst_n            in   1                      asynchronous reset, active-low
//  in_valid         in   1                      operands valid
//  in_ready         out  1                      block can accept operands
//  weight           in   size*size*data_size    W(i,j) at index i*size+j
//  bias             in   size*data_size         b(i)
//  x                in   size*data_size         x(j)
//  dense_type       in   dense_type_size        0 linear, 1 ReLU, others reserved -> linear
//  out_valid        out  1                      results valid
//  out_ready        in   1                      consumer takes results
//  z                out  size*data_size         pre-activation, z(i)
//  predict_value    out  size*data_size         post-activation, act(z(i))
// BEHAVIOUR
//  - Vector element k occupies bits [k*data_size +: data_size].
//  - Reset (rst_n low, async): state IDLE, in_ready=1 after release, out_valid=0,
//    z=0, predict_value=0, counters/accumulator=0. Mid-operation reset aborts the job.
//  - States: IDLE -> MAC -> FIN -> (MAC | DONE) -> IDLE.
//  - IDLE: in_ready=1. in_valid&in_ready at edge: capture weight/bias/x/dense_type,
//    i=0, j=0, acc=0, go MAC. Inputs not sampled again until next accept.
//  - MAC: each cycle acc += W(i,j)*x(j); acc width 2*data_size+$clog2(size)+1, no overflow.
//    j==size-1 -> FIN, else j++.
//  - FIN (1 cycle): t = (acc >>> frac_bits) + sign-extended b(i); z(i)=sat(t) to
//    [-2^(data_size-1), 2^(data_size-1)-1]; predict_value(i)=ReLU ? max(z(i),0) : z(i).
//    i==size-1 -> DONE, else i++, j=0, acc=0, MAC.
//  - Shift is arithmetic (truncate toward -inf); no rounding.
//  - Latency: out_valid high size*(size+1) edges after accept edge (12 for size=3).
//  - DONE: out_valid=1, in_ready=0; z/predict_value stable until out_valid&out_ready;
//    then IDLE. in_valid in DONE ignored (no same-cycle re-accept).
//  - z/predict_value keep last completed results outside DONE; partial updates during
//    FIN are visible but out_valid=0 marks them invalid.
//  - in_ready=0 in MAC/FIN/DONE; in_valid there has no effect.
// STRUCTURE
//  - Shared package nn_pkg: dense_type encodings (DENSE_LINEAR=0, DENSE_RELU=1),
//    default frac_bits, FSM state enum; shared with the backward-pass blocks.
//  - Sub-module dense_sat_act (combinational): shift, bias add, saturate, activation.
//  - Top holds FSM, i/j counters, operand registers, accumulator, output registers.
// TESTING (Q8.8, size=3; 1.0=0x0100)
//  1 W=I, x=(0x0100,0x0200,0xFD00), b=0, type 0 -> z=pv=x; out_valid 12 edges after accept.
//  2 same, type 1 -> z=(0x0100,0x0200,0xFD00), pv=(0x0100,0x0200,0x0000).
//  3 W=all 0x7FFF, x=all 0x7FFF -> z=all 0x7FFF; x=all 0x8000 -> z=all 0x8000 (saturation).
//  4 x=0, W=any, b=(0x0080,0xFF80,0) type 1 -> z=(0x0080,0xFF80,0), pv=(0x0080,0,0).
//  5 out_ready low 5 cycles after out_valid, in_valid high -> outputs stable, in_ready=0,
//    no accept; out_ready high -> IDLE next edge, accept on the following edge.
//  6 rst_n low during 5th MAC cycle -> out_valid=0, z=pv=0 immediately; in_ready=1
//    after release; next job from test 1 completes correctly.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared dense-layer definitions: activation select codes, default Q format, FSM states.
// Also used by the backward-pass blocks, so keep encodings stable.
package nn_pkg;

  localparam int DEFAULT_FRAC_BITS = 8;

  localparam logic [3:0] DENSE_LINEAR = 4'd0;
  localparam logic [3:0] DENSE_RELU   = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_FIN  = 2'd2,
    ST_DONE = 2'd3
  } dense_state_t;

endpackage

// File: rtl/dense_sat_act.sv
// Combinational neuron tail: acc >>> frac_bits, add bias, saturate to data_size, activation.
// Zero latency; no handshake.
module dense_sat_act
  import nn_pkg::*;
#(
  parameter int acc_w           = 35,
  parameter int data_size       = 16,
  parameter int frac_bits       = DEFAULT_FRAC_BITS,
  parameter int dense_type_size = 4
) (
  input  logic signed [acc_w-1:0]           acc,
  input  logic signed [data_size-1:0]       bias,
  input  logic        [dense_type_size-1:0] dense_type,
  output logic signed [data_size-1:0]       z_elem,
  output logic signed [data_size-1:0]       pv_elem
);

  localparam int TW = acc_w + 1;

  logic signed [acc_w-1:0]       shifted;
  logic signed [TW-1:0]          sum;
  logic        [TW-data_size:0]  hi_bits;
  logic                          is_relu;

  assign shifted = acc >>> frac_bits;
  assign sum     = {shifted[acc_w-1], shifted} + {{(TW-data_size){bias[data_size-1]}}, bias};
  // Sum fits in data_size bits exactly when everything above the result sign bit agrees.
  assign hi_bits = sum[TW-1:data_size-1];
  assign is_relu = (dense_type == dense_type_size'(DENSE_RELU));

  always_comb begin
    z_elem = sum[data_size-1:0];
    if (!((&hi_bits) || (~|hi_bits))) begin
      z_elem = sum[TW-1] ? {1'b1, {(data_size-1){1'b0}}} : {1'b0, {(data_size-1){1'b1}}};
    end
    pv_elem = (is_relu && z_elem[data_size-1]) ? '0 : z_elem;
  end

endmodule

// File: rtl/forward_dense.sv
// Dense layer forward pass z = W*x + b, pv = act(z); one MAC per cycle, size*(size+1) cycles.
// in_ready only in IDLE; results held with out_valid until out_ready.
module forward_dense
  import nn_pkg::*;
#(
  parameter int size            = 3,
  parameter int data_size       = 16,
  parameter int frac_bits       = DEFAULT_FRAC_BITS,
  parameter int dense_type_size = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [size*size*data_size-1:0]    weight,
  input  logic [size*data_size-1:0]         bias,
  input  logic [size*data_size-1:0]         x,
  input  logic [dense_type_size-1:0]        dense_type,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [size*data_size-1:0]         z,
  output logic [size*data_size-1:0]         predict_value
);

  localparam int ACC_W = 2*data_size + $clog2(size) + 1;
  localparam int CNT_W = (size > 1) ? $clog2(size) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(size - 1);

  dense_state_t state;

  logic [size*size*data_size-1:0] weight_q;
  logic [size*data_size-1:0]      bias_q;
  logic [size*data_size-1:0]      x_q;
  logic [dense_type_size-1:0]     type_q;
  logic [CNT_W-1:0]               i_cnt;
  logic [CNT_W-1:0]               j_cnt;
  logic signed [ACC_W-1:0]        acc;

  logic signed [data_size-1:0]    w_sel;
  logic signed [data_size-1:0]    x_sel;
  logic signed [data_size-1:0]    b_sel;
  logic signed [2*data_size-1:0]  prod;
  logic signed [data_size-1:0]    z_elem;
  logic signed [data_size-1:0]    pv_elem;

  // Constant-index operand muxes keep every part-select static.
  always_comb begin
    w_sel = '0;
    x_sel = '0;
    b_sel = '0;
    for (int ii = 0; ii < size; ii++) begin
      if (CNT_W'(ii) == i_cnt) b_sel = bias_q[ii*data_size +: data_size];
      if (CNT_W'(ii) == j_cnt) x_sel = x_q[ii*data_size +: data_size];
      for (int jj = 0; jj < size; jj++) begin
        if (CNT_W'(ii) == i_cnt && CNT_W'(jj) == j_cnt)
          w_sel = weight_q[(ii*size+jj)*data_size +: data_size];
      end
    end
  end

  assign prod = w_sel * x_sel;

  dense_sat_act #(
    .acc_w          (ACC_W),
    .data_size      (data_size),
    .frac_bits      (frac_bits),
    .dense_type_size(dense_type_size)
  ) u_sat_act (
    .acc       (acc),
    .bias      (b_sel),
    .dense_type(type_q),
    .z_elem    (z_elem),
    .pv_elem   (pv_elem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      z             <= '0;
      predict_value <= '0;
      weight_q      <= '0;
      bias_q        <= '0;
      x_q           <= '0;
      type_q        <= '0;
      i_cnt         <= '0;
      j_cnt         <= '0;
      acc           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            weight_q <= weight;
            bias_q   <= bias;
            x_q      <= x;
            type_q   <= dense_type;
            i_cnt    <= '0;
            j_cnt    <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc + {{(ACC_W-2*data_size){prod[2*data_size-1]}}, prod};
          if (j_cnt == LAST) state <= ST_FIN;
          else               j_cnt <= j_cnt + 1'b1;
        end
        ST_FIN: begin
          for (int ii = 0; ii < size; ii++) begin
            if (CNT_W'(ii) == i_cnt) begin
              z[ii*data_size +: data_size]             <= z_elem;
              predict_value[ii*data_size +: data_size] <= pv_elem;
            end
          end
          if (i_cnt == LAST) begin
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            i_cnt <= i_cnt + 1'b1;
            j_cnt <= '0;
            acc   <= '0;
            state <= ST_MAC;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
